// File: rtl/pow_5_pkg.sv
// Shared constants for the pow_5 pipeline and its result FIFO.
// Lane indices locate each partial product in the pipeline's valid and result vectors.
// N_LANES sets the width of those vectors.
package pow_5_pkg;

  localparam int W           = 8;
  localparam int POW5_STAGES = 5;
  localparam int N_LANES     = 4;

  localparam int LANE_P5 = 0;
  localparam int LANE_P4 = 1;
  localparam int LANE_P3 = 2;
  localparam int LANE_P2 = 3;

endpackage

// File: rtl/pow_5_res_fifo_mem.sv
// Purpose: DEPTH x w storage for the result FIFO. It has one synchronous write port and one asynchronous read port.
// Latency: a write lands on the clock edge, and a read is combinational from rd_addr.
// Backpressure: none here; the parent only asserts wr_en when a slot is free.
module pow_5_res_fifo_mem #(
  parameter int w     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [w-1:0]  wr_dat,
  input  logic [AW-1:0] rd_addr,
  output logic [w-1:0]  rd_dat
);

  logic [w-1:0] mem [DEPTH];

  // Write one entry per enabled edge. The array has no reset because the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/pow_5_res_fifo.sv
// Purpose: captures the n^5 lane of the pow_5 pipeline into a DEPTH-entry FIFO with a valid/ready output.
// Latency: m_valid follows a push edge by 1 cycle. With POW5_RES_FIFO_BYPASS_EN defined, an empty FIFO whose consumer is ready passes the item through in the same cycle.
// Backpressure: clk_en = en_in & ~full, so the pipeline stalls while the FIFO is full and no result is lost.
module pow_5_res_fifo
  import pow_5_pkg::*;
#(
  parameter int  w     = W,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_in,
  output logic                 clk_en,
  input  logic [N_LANES-1:0]   res_vld,
  input  logic [N_LANES*w-1:0] res,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [w-1:0]         m_data,
  output logic [AW:0]          count,
  output logic                 full,
  output logic                 empty
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [w-1:0]  rd_dat;
  logic [w-1:0]  p5_dat;
  logic          push;
  logic          wr_en;
  logic          pop;

  // The other lanes carry partial products of different arguments and are deliberately dropped.
  logic unused_lanes;
  assign unused_lanes = ^{res_vld[N_LANES-1:1], res[N_LANES*w-1:w]};

  assign p5_dat = res[LANE_P5*w +: w];

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  // While the FIFO is full the pipeline freezes, so a result held at its output is pushed only once.
  assign clk_en = en_in & ~full;
  assign push   = clk_en & res_vld[LANE_P5];

`ifdef POW5_RES_FIFO_BYPASS_EN
  logic bypass;
  assign bypass  = empty & push & m_ready;
  assign m_valid = ~empty | bypass;
  assign m_data  = empty ? p5_dat : rd_dat;
  assign wr_en   = push & ~bypass;
`else
  assign m_valid = ~empty;
  assign m_data  = rd_dat;
  assign wr_en   = push;
`endif

  // Storage pops happen only when an entry is held, so a ready consumer facing an empty FIFO pops nothing.
  assign pop = ~empty & m_ready;

  pow_5_res_fifo_mem #(
    .w     (w),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_dat  (p5_dat),
    .rd_addr (rd_ptr),
    .rd_dat  (rd_dat)
  );

  // The pointers wrap modulo DEPTH through their natural AW-bit width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy tracks storage writes and pops. Bypassed items never touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pow_5_res_fifo.sv
// Self-checking bench for pow_5_res_fifo (w=8, DEPTH=4). Stimulus stands in for the pow_5 pipeline output.
// A negedge scoreboard models the queue, flags and clk_en, and checks every pop against the expected n^5 mod 256.
module tb_pow_5_res_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_in;
  logic        clk_en;
  logic [3:0]  res_vld;
  logic [31:0] res;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned n_pops  = 0;
  logic        mon_en  = 1'b0;
  logic [7:0]  sb_q[$];

  always #5 clk = ~clk;

  pow_5_res_fifo #(.w(8), .DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_in   (en_in),
    .clk_en  (clk_en),
    .res_vld (res_vld),
    .res     (res),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  function automatic logic [7:0] p5(input int n);
    int v;
    v = n * n * n * n * n;
    return v[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: at each negedge, check flags against the model and then apply the push and pop that the next posedge will perform.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      logic pu, po, ev;
      pu = clk_en && res_vld[0];
      ev = (sb_q.size() != 0);
`ifdef POW5_RES_FIFO_BYPASS_EN
      ev = ev || (pu && m_ready);
`endif
      chk("sb_count", 32'(count), 32'(sb_q.size()));
      chk("sb_full", 32'(full), 32'(sb_q.size() == 4));
      chk("sb_clk_en", 32'(clk_en), 32'(en_in && sb_q.size() != 4));
      chk("sb_m_valid", 32'(m_valid), 32'(ev));
      po = m_valid && m_ready;
      if (pu) sb_q.push_back(res[7:0]);
      if (po) begin
        if (sb_q.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
        else chk("sb_m_data", 32'(m_data), 32'(sb_q.pop_front()));
        n_pops++;
      end
    end
  end

  always @(negedge rst_n) sb_q.delete();

  // Drives one pipeline result and holds it across stalled cycles until an edge with clk_en=1 takes it.
  task automatic send(input int n);
    logic ok;
    int   guard;
    res_vld = {3'($urandom), 1'b1};
    res     = {24'($urandom), p5(n)};
    ok      = 1'b0;
    guard   = 0;
    while (!ok) begin
      @(negedge clk);
      ok = clk_en;
      @(posedge clk);
      #1;
      guard++;
      if (guard > 200) begin
        chk("send_timeout", 32'(guard), 32'(0));
        ok = 1'b1;
      end
    end
    res_vld = {3'($urandom), 1'b0};
    res     = 32'($urandom);
  endtask

  task automatic wait_empty(input string name);
    int guard;
    guard = 0;
    while (!empty && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk(name, 32'(empty), 32'(1));
  endtask

  typedef struct {
    int         n;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];
  bit   stream_done;
  int   pops0;

  initial begin
    vecs[0] = '{3, 8'd243};
    vecs[1] = '{0, 8'd0};
    vecs[2] = '{1, 8'd1};
    vecs[3] = '{2, 8'd32};
    vecs[4] = '{4, 8'd0};
    vecs[5] = '{5, 8'd53};
    vecs[6] = '{7, 8'd167};
    vecs[7] = '{255, 8'd255};

    // Reset state, with clk_en following en_in while reset is held
    rst_n = 1'b0; en_in = 1'b1; m_ready = 1'b0; res_vld = 4'b1110; res = 32'hFFFF_FF00;
    #12;
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_m_valid", 32'(m_valid), 32'(0));
    chk("rst_clk_en", 32'(clk_en), 32'(1));
    en_in = 1'b0; #1;
    chk("rst_clk_en_off", 32'(clk_en), 32'(0));
    en_in = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1; res_vld = 4'b0000;
    mon_en = 1'b1;

    // Single results from a table, each shown one cycle after its push and then popped
    for (int i = 0; i < 8; i++) begin
      m_ready = 1'b0;
      send(vecs[i].n);
      @(negedge clk);
      chk("vec_m_valid", 32'(m_valid), 32'(1));
      chk("vec_m_data", 32'(m_data), 32'(vecs[i].exp));
      chk("vec_count", 32'(count), 32'(1));
      @(posedge clk); #1;
      m_ready = 1'b1;
      @(posedge clk); #1;
      chk("vec_count_after_pop", 32'(count), 32'(0));
    end

    // Fill to full with m_ready low; the fifth result stalls and is pushed exactly once
    m_ready = 1'b0;
    pops0 = n_pops;
    fork
      begin
        for (int n = 1; n <= 5; n++) send(n);
      end
      begin
        int g;
        g = 0;
        while (count != 3'd4 && g < 100) begin @(posedge clk); #1; g++; end
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_full", 32'(full), 32'(1));
          chk("stall_clk_en", 32'(clk_en), 32'(0));
          chk("stall_m_data", 32'(m_data), 32'(1));
          chk("stall_count", 32'(count), 32'(4));
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    wait_empty("stall_drain");
    chk("stall_pop_total", 32'(n_pops - pops0), 32'(5));

    // Steady stream at count=2 with push and pop on every edge
    m_ready = 1'b0;
    send(10); send(11);
    m_ready = 1'b1;
    fork
      begin
        for (int n = 20; n < 28; n++) send(n);
      end
      begin
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          chk("stream_count", 32'(count), 32'(2));
        end
      end
    join
    wait_empty("stream_drain");

    // Pointer wrap with m_ready toggling every cycle
    pops0 = n_pops;
    stream_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 10; n++) send(n);
        stream_done = 1'b1;
      end
      begin
        m_ready = 1'b1;
        while (!stream_done) begin @(posedge clk); #1; m_ready = ~m_ready; end
        m_ready = 1'b1;
      end
    join
    wait_empty("wrap_drain");
    chk("wrap_pop_total", 32'(n_pops - pops0), 32'(10));

    // Asynchronous reset with three entries held flushes the FIFO
    m_ready = 1'b0;
    send(6); send(7); send(8);
    @(negedge clk);
    chk("flush_count_before", 32'(count), 32'(3));
    #2; rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("flush_empty", 32'(empty), 32'(1));
    chk("flush_m_valid", 32'(m_valid), 32'(0));
    chk("flush_count", 32'(count), 32'(0));

`ifdef POW5_RES_FIFO_BYPASS_EN
    // An empty FIFO with m_ready high passes the item through in the same cycle without storing it
    m_ready = 1'b1;
    res_vld = 4'b0001; res = {24'h0, p5(2)};
    @(negedge clk);
    chk("byp_m_valid", 32'(m_valid), 32'(1));
    chk("byp_m_data", 32'(m_data), 32'(32));
    chk("byp_count", 32'(count), 32'(0));
    @(posedge clk); #1;
    res_vld = 4'b0000;
    @(negedge clk);
    chk("byp_count_after", 32'(count), 32'(0));
`endif

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
